// File: rtl/instruction_memory_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Word geometry and FSM state codes live here so the top and serializer agree.
package instruction_memory_loader_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  // Little-endian lane select: lane 0 is the least significant byte.
  function automatic logic [7:0] byte_lane(input logic [DEF_DATA_WIDTH-1:0] word,
                                           input logic [BYTE_IDX_W-1:0] idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/instruction_memory_loader_if.sv
// Host/boot word channel plus byte-write port to the instruction array.
// The loader uses the slave modport; the host side uses master.
interface instruction_memory_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);

  logic                  iStart;
  logic [ADDR_WIDTH-1:0] iBaseAddr;
  logic [ADDR_WIDTH-1:0] iWordCount;
  logic                  iWordValid;
  logic [DATA_WIDTH-1:0] iWord;
  logic                  oWordReady;
  logic                  oMemWrEn;
  logic [ADDR_WIDTH-1:0] oMemAddr;
  logic [7:0]            oMemData;
  logic                  oBusy;
  logic                  oCpuHold;
  logic                  oDone;

  modport master (
    output iStart, iBaseAddr, iWordCount, iWordValid, iWord,
    input  oWordReady, oMemWrEn, oMemAddr, oMemData, oBusy, oCpuHold, oDone
  );

  modport slave (
    input  iStart, iBaseAddr, iWordCount, iWordValid, iWord,
    output oWordReady, oMemWrEn, oMemAddr, oMemData, oBusy, oCpuHold, oDone
  );

endinterface

// File: rtl/instruction_memory_loader_serializer.sv
// Word buffer that emits one byte per cycle, LS byte first, at consecutive addresses.
// The address counter is seeded per session and keeps running across words.
module instr_word_serializer
  import instruction_memory_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_addr_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  output logic                  buf_valid_o,
  output logic                  last_byte_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [7:0]            data_o
);

  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  buf_valid_q, buf_valid_d;
  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    byte_idx_d  = byte_idx_q;
    addr_d      = addr_q;

    // byte_idx wraps back to 0 as the last lane drains, so an empty buffer always restarts at lane 0.
    if (buf_valid_q) begin
      byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
      addr_d     = addr_q + ADDR_WIDTH'(1);
      if (byte_idx_q == LAST_BYTE_IDX) begin
        buf_valid_d = 1'b0;
      end
    end

    if (set_addr_i) begin
      addr_d = base_addr_i & ~ADDR_WIDTH'(BYTES_PER_WORD - 1);
    end

    if (load_i) begin
      buf_d       = word_i;
      buf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      byte_idx_q  <= '0;
      addr_q      <= '0;
    end else begin
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      byte_idx_q  <= byte_idx_d;
      addr_q      <= addr_d;
    end
  end

  assign buf_valid_o = buf_valid_q;
  assign last_byte_o = buf_valid_q && (byte_idx_q == LAST_BYTE_IDX);
  assign addr_o      = addr_q;
  assign data_o      = byte_lane(buf_q, byte_idx_q);

endmodule

// File: rtl/instruction_memory_loader.sv
// Load-session controller: accepts instruction words and streams them into the byte-wide ROM,
// holding the CPU off until the session completes.
//
//   state | meaning
//   IDLE  | waiting for iStart; base address and word count latched on start
//   LOAD  | accepting words and writing bytes; CPU held
//   DONE  | single-cycle end-of-session pulse on oDone
module instruction_memory_loader
  import instruction_memory_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input logic                        clk,
  input logic                        rst,
  instruction_memory_loader_if.slave bus
);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] words_left_q, words_left_d;

  logic                  session_start;
  logic                  word_ready;
  logic                  word_accept;
  logic                  busy;
  logic                  done;
  logic                  ser_buf_valid;
  logic                  ser_last_byte;
  logic [ADDR_WIDTH-1:0] ser_addr;
  logic [7:0]            ser_data;

  assign word_accept = word_ready && bus.iWordValid;

  always_comb begin
    state_d       = state_q;
    words_left_d  = words_left_q;
    session_start = 1'b0;
    word_ready    = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.iStart) begin
          session_start = 1'b1;
          words_left_d  = bus.iWordCount;
          state_d       = (bus.iWordCount == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy = 1'b1;
        // Ready on the last byte lets the next word land without a bubble.
        word_ready = (words_left_q != '0) && (!ser_buf_valid || ser_last_byte);
        if (word_ready && bus.iWordValid) begin
          words_left_d = words_left_q - ADDR_WIDTH'(1);
        end
        if ((words_left_q == '0) && ser_last_byte) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      words_left_q <= '0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
    end
  end

  instr_word_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_serializer (
    .clk         (clk),
    .rst         (rst),
    .set_addr_i  (session_start),
    .base_addr_i (bus.iBaseAddr),
    .load_i      (word_accept),
    .word_i      (bus.iWord),
    .buf_valid_o (ser_buf_valid),
    .last_byte_o (ser_last_byte),
    .addr_o      (ser_addr),
    .data_o      (ser_data)
  );

  // The strobe is cut combinationally by rst so an aborted session never lands a stray byte.
  assign bus.oWordReady = word_ready;
  assign bus.oMemWrEn   = ser_buf_valid && !rst;
  assign bus.oMemAddr   = ser_addr;
  assign bus.oMemData   = ser_data;
  assign bus.oBusy      = busy;
  assign bus.oCpuHold   = busy;
  assign bus.oDone      = done;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed-plus-random bench for instruction_memory_loader; expectations come from a
// byte-image model (word k, lane j lands at aligned_base + 4k + j mod 4096).
module tb_instruction_memory_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  instruction_memory_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus ();

  instruction_memory_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem_tb [4096];
  logic [11:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  logic [31:0] fixed_w [$];

  int cycle = 0;
  int first_wr, last_wr, done_cycle;
  int done_count, busy_count, xfer_count, hold_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, return 1 time unit after the next posedge.
  task automatic tick();
    @(negedge clk);
    cycle++;
    if (bus.oMemWrEn === 1'b1) begin
      mem_tb[bus.oMemAddr] = bus.oMemData;
      wr_addr_q.push_back(bus.oMemAddr);
      wr_data_q.push_back(bus.oMemData);
      if (first_wr < 0) first_wr = cycle;
      last_wr = cycle;
    end
    if (bus.oDone === 1'b1) begin
      done_count++;
      if (done_cycle < 0) done_cycle = cycle;
    end
    if (bus.oBusy === 1'b1) busy_count++;
    if (bus.oCpuHold !== bus.oBusy) hold_bad++;
    if (bus.iWordValid && bus.oWordReady === 1'b1) xfer_count++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    wr_addr_q.delete();
    wr_data_q.delete();
    first_wr   = -1;
    last_wr    = -1;
    done_cycle = -1;
    done_count = 0;
    busy_count = 0;
    xfer_count = 0;
    hold_bad   = 0;
  endtask

  task automatic run_session(input string name, input logic [11:0] base, input int count,
                             input bit use_fixed, input bit rand_stall, input bit mid_start,
                             input bit long_stall);
    logic [31:0] words [$];
    int          src_idx;
    int          budget;
    int          sc;
    int          stall_wr;
    int          start_cycle;
    int          pre_x;
    int          pre_w;
    int          exp_a;
    bit          stall;
    logic [31:0] fetched;
    logic [31:0] exp_b;

    words.delete();
    if (use_fixed) begin
      foreach (fixed_w[k]) words.push_back(fixed_w[k]);
    end else begin
      for (int k = 0; k < count; k++) words.push_back($urandom);
    end
    words.push_back($urandom);  // surplus word: must stay pending, never consumed

    clear_stats();
    src_idx  = 0;
    sc       = -1;
    stall_wr = 0;

    bus.iStart     = 1'b1;
    bus.iBaseAddr  = base;
    bus.iWordCount = 12'(count);
    bus.iWordValid = 1'b0;
    tick();
    start_cycle = cycle;

    budget = 100 + 40 * count;
    while (done_count == 0 && budget > 0) begin
      if (mid_start && (cycle - start_cycle) == 3) begin
        bus.iStart     = 1'b1;
        bus.iBaseAddr  = ~base;
        bus.iWordCount = 12'd7;
      end else begin
        bus.iStart = 1'b0;
      end
      if (long_stall && xfer_count == 1 && sc < 0) sc = 0;
      stall = (sc >= 0 && sc < 9) || (rand_stall && $urandom_range(0, 3) == 0);
      bus.iWordValid = !stall && (src_idx < words.size());
      bus.iWord      = (src_idx < words.size()) ? words[src_idx] : 32'h0;
      pre_x = xfer_count;
      pre_w = wr_addr_q.size();
      tick();
      if (xfer_count != pre_x) src_idx++;
      if (sc >= 4 && sc < 9) stall_wr += wr_addr_q.size() - pre_w;
      if (sc >= 0) sc++;
      budget--;
    end
    bus.iStart     = 1'b0;
    bus.iWordValid = 1'b0;
    tick();
    tick();

    chk({name, "/done_pulses"}, done_count, 1);
    chk({name, "/words_accepted"}, xfer_count, count);
    chk({name, "/write_count"}, wr_addr_q.size(), 4 * count);
    chk({name, "/busy_cycles"}, busy_count, done_cycle - start_cycle - 1);
    chk({name, "/hold_eq_busy"}, hold_bad, 0);

    for (int i = 0; i < wr_addr_q.size() && i < 4 * count; i++) begin
      exp_a = ((int'(base) & 32'hFFC) + i) % 4096;
      exp_b = (words[i / 4] >> (8 * (i % 4))) & 32'hFF;
      chk($sformatf("%s/addr[%0d]", name, i), wr_addr_q[i], exp_a);
      chk($sformatf("%s/data[%0d]", name, i), wr_data_q[i], exp_b);
    end

    for (int k = 0; k < count; k++) begin
      fetched = 32'h0;
      for (int j = 0; j < 4; j++) begin
        exp_a   = ((int'(base) & 32'hFFC) + 4 * k + j) % 4096;
        fetched = fetched | (32'(mem_tb[exp_a]) << (8 * j));
      end
      chk($sformatf("%s/fetch[%0d]", name, k), fetched, words[k]);
    end

    if (count == 0) begin
      chk({name, "/done_latency"}, done_cycle - start_cycle, 1);
    end else begin
      chk({name, "/first_write_latency"}, first_wr - start_cycle, 2);
      chk({name, "/done_after_last"}, done_cycle - last_wr, 1);
    end
    if (!rand_stall && !long_stall && count > 0) begin
      chk({name, "/contiguous_writes"}, last_wr - first_wr + 1, 4 * count);
    end
    if (long_stall) begin
      chk({name, "/writes_in_stall"}, stall_wr, 0);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          budget;
    logic [31:0] w;
    logic [7:0]  exp_bytes [8];

    foreach (mem_tb[i]) mem_tb[i] = 8'h00;
    clear_stats();

    // Reset held 3 cycles with iStart high: every output must be quiet.
    bus.iStart     = 1'b1;
    bus.iBaseAddr  = 12'h123;
    bus.iWordCount = 12'd3;
    bus.iWordValid = 1'b0;
    bus.iWord      = 32'h0;
    rst            = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset/ready", bus.oWordReady, 0);
    chk("reset/wr_en", bus.oMemWrEn, 0);
    chk("reset/addr", bus.oMemAddr, 0);
    chk("reset/data", bus.oMemData, 0);
    chk("reset/busy", bus.oBusy, 0);
    chk("reset/hold", bus.oCpuHold, 0);
    chk("reset/done", bus.oDone, 0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    bus.iStart = 1'b0;
    tick();
    chk("post_reset/idle_busy", busy_count, 0);

    // Known two-word program.
    fixed_w.delete();
    fixed_w.push_back(32'h00500093);
    fixed_w.push_back(32'h00100113);
    run_session("prog2", 12'h010, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_bytes = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("prog2/rom[0x%0h]", 16 + i), mem_tb[16 + i], exp_bytes[i]);
    end

    run_session("stream4", 12'h200, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    run_session("count0", 12'h300, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_session("wrap", 12'hFFE, 2, 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort after two bytes of the first word.
    clear_stats();
    bus.iStart     = 1'b1;
    bus.iBaseAddr  = 12'h100;
    bus.iWordCount = 12'd2;
    tick();
    bus.iStart     = 1'b0;
    w              = $urandom;
    bus.iWord      = w;
    bus.iWordValid = 1'b1;
    budget         = 20;
    while (wr_addr_q.size() < 2 && budget > 0) begin
      tick();
      if (xfer_count > 0) bus.iWordValid = 1'b0;
      budget--;
    end
    chk("abort/two_bytes_seen", wr_addr_q.size(), 2);
    bus.iWordValid = 1'b0;
    rst            = 1'b1;
    @(negedge clk);
    chk("abort/wr_en_in_reset", bus.oMemWrEn, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort/busy_after", bus.oBusy, 0);
    chk("abort/done_after", bus.oDone, 0);
    chk("abort/ready_after", bus.oWordReady, 0);
    chk("abort/byte0", mem_tb[12'h100], w[7:0]);
    chk("abort/byte1", mem_tb[12'h101], w[15:8]);
    @(posedge clk);
    #1;

    run_session("restart_stall", 12'h041, 3, 1'b0, 1'b0, 1'b1, 1'b1);

    for (int s = 0; s < 4; s++) begin
      run_session($sformatf("rand%0d", s), 12'($urandom_range(0, 4095)),
                  int'($urandom_range(1, 6)), 1'b0, 1'b1, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
